// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver: baud tick generator, 2-flop rx synchroniser,
// frame FSM (5-8 data bits, none/even/odd parity, 1 or 2 stop bits) and a
// first-word-fall-through receive FIFO with per-word parity/framing flags.
`timescale 1ns/1ps
module uart_rx_cfg #(
    parameter int DBIT_MAX   = 8,
    parameter int OVERSAMPLE = 16,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 11
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic [DIV_W-1:0]              divisor,
    input  logic [1:0]                    data_bits,
    input  logic [1:0]                    parity_mode,
    input  logic                          two_stop,
    input  logic                          rd_en,
    input  logic                          clr_overrun,
    output logic [DBIT_MAX-1:0]           r_data,
    output logic                          r_perr,
    output logic                          r_ferr,
    output logic                          rx_empty,
    output logic                          rx_full,
    output logic [$clog2(FIFO_DEPTH):0]   rx_count,
    output logic                          overrun,
    output logic                          break_det
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DBIT_MAX);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } state_t;

    logic [DIV_W-1:0]    divCnt_q, divCnt_d;
    logic                tick;
    logic                sync1_q, sync2_q, rxS;

    state_t              state_q;
    logic [SW-1:0]       s_q;
    logic [NW-1:0]       n_q;
    logic                stopIdx_q;
    logic [1:0]          cfgBits_q;
    logic [1:0]          cfgPar_q;
    logic                cfgTwo_q;
    logic [DBIT_MAX-1:0] data_q;
    logic                perr_q, ferr_q, parBit_q;

    logic [NW-1:0]       lastIdx;
    logic                parityOn, expParity;
    logic                sampleEnd, wrEn, wrFerr, wrBreak;

    logic [DBIT_MAX+1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]       wrPtr_q, rdPtr_q;
    logic [CW-1:0]       count_q, count_d;
    logic                isFull, doRd, doWr, ovSet;

    // Baud tick: count 0..divisor, tick on the terminal count and wrap
    always_comb begin
        tick     = (divCnt_q == divisor);
        divCnt_d = tick ? '0 : divCnt_q + DIV_W'(1);
    end

    // Tick counter register
    always_ff @(posedge clk) begin
        if (reset) divCnt_q <= '0;
        else       divCnt_q <= divCnt_d;
    end

    // Two-flop synchroniser for the asynchronous rx pin, idles high
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rx;
            sync2_q <= sync1_q;
        end
    end

    assign rxS = sync2_q;

    // Frame-level decode: last data index, parity expectation and the write strobe
    always_comb begin
        lastIdx   = NW'(cfgBits_q) + NW'(4);
        parityOn  = (cfgPar_q == 2'b01) || (cfgPar_q == 2'b10);
        expParity = (^data_q) ^ (cfgPar_q == 2'b10);
        sampleEnd = tick && (s_q == S_END);
        wrEn      = (state_q == ST_STOP) && sampleEnd && (!cfgTwo_q || stopIdx_q);
        wrFerr    = ferr_q | ~rxS;
        wrBreak   = wrFerr && (data_q == '0) && !parBit_q;
    end

    // Receive FSM: start validation, data/parity/stop sampling at bit centres
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            s_q       <= '0;
            n_q       <= '0;
            stopIdx_q <= 1'b0;
            cfgBits_q <= 2'b00;
            cfgPar_q  <= 2'b00;
            cfgTwo_q  <= 1'b0;
            data_q    <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            parBit_q  <= 1'b0;
            break_det <= 1'b0;
        end else begin
            break_det <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (!rxS) begin
                        state_q   <= ST_START;
                        s_q       <= '0;
                        n_q       <= '0;
                        stopIdx_q <= 1'b0;
                        cfgBits_q <= data_bits;
                        cfgPar_q  <= parity_mode;
                        cfgTwo_q  <= two_stop;
                        data_q    <= '0;
                        perr_q    <= 1'b0;
                        ferr_q    <= 1'b0;
                        parBit_q  <= 1'b0;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        if (s_q == S_MID) begin
                            s_q     <= '0;
                            n_q     <= '0;
                            state_q <= rxS ? ST_IDLE : ST_DATA;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (s_q == S_END) begin
                            s_q         <= '0;
                            data_q[n_q] <= rxS;
                            n_q         <= n_q + NW'(1);
                            if (n_q == lastIdx) state_q <= parityOn ? ST_PARITY : ST_STOP;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick) begin
                        if (s_q == S_END) begin
                            s_q       <= '0;
                            parBit_q  <= rxS;
                            perr_q    <= (rxS != expParity);
                            stopIdx_q <= 1'b0;
                            state_q   <= ST_STOP;
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (s_q == S_END) begin
                            s_q <= '0;
                            if (!rxS) ferr_q <= 1'b1;
                            if (wrEn) begin
                                break_det <= wrBreak;
                                stopIdx_q <= 1'b0;
                                state_q   <= wrFerr ? ST_WAIT_HIGH : ST_IDLE;
                            end else begin
                                stopIdx_q <= 1'b1;
                            end
                        end else begin
                            s_q <= s_q + SW'(1);
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rxS) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // FIFO control: read only when non-empty; write when space or a read frees a slot
    always_comb begin
        isFull  = (count_q == CW'(FIFO_DEPTH));
        doRd    = rd_en && (count_q != '0);
        doWr    = wrEn && (!isFull || doRd);
        ovSet   = wrEn && isFull && !doRd;
        count_d = count_q;
        if (doWr && !doRd)      count_d = count_q + CW'(1);
        else if (doRd && !doWr) count_d = count_q - CW'(1);
    end

    // FIFO storage: {perr, ferr, data} per entry
    always_ff @(posedge clk) begin
        if (doWr) mem_q[wrPtr_q] <= {perr_q, wrFerr, data_q};
    end

    // FIFO pointers, occupancy and sticky overrun (set beats clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
            overrun <= 1'b0;
        end else begin
            if (doWr) wrPtr_q <= wrPtr_q + AW'(1);
            if (doRd) rdPtr_q <= rdPtr_q + AW'(1);
            count_q <= count_d;
            if (ovSet)            overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    // Head-of-FIFO presentation, forced to zero while empty
    always_comb begin
        rx_empty = (count_q == '0);
        rx_full  = isFull;
        rx_count = count_q;
        {r_perr, r_ferr, r_data} = rx_empty ? '0 : mem_q[rdPtr_q];
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames at 64 clk/bit, scoreboard of expected words.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

    localparam int BIT_CLK = 64;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, rx, two_stop, rd_en, clr_overrun;
    logic [10:0] divisor;
    logic [1:0]  data_bits, parity_mode;
    logic [7:0]  r_data;
    logic        r_perr, r_ferr, rx_empty, rx_full, overrun, break_det;
    logic [4:0]  rx_count;

    int   vectors     = 0;
    int   miscompares = 0;
    int   breakCnt    = 0;
    int   brk0;
    exp_t sbQ[$];
    logic [7:0] d;

    uart_rx_cfg dut (
        .clk(clk), .reset(reset), .rx(rx), .divisor(divisor),
        .data_bits(data_bits), .parity_mode(parity_mode), .two_stop(two_stop),
        .rd_en(rd_en), .clr_overrun(clr_overrun),
        .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr),
        .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
        .overrun(overrun), .break_det(break_det)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count break_det pulses
    always @(posedge clk) if (break_det === 1'b1) breakCnt <= breakCnt + 1;

    // Runaway guard
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic expPerr(input logic [7:0] data, input int nbits,
                                     input bit odd, input logic parBit);
        logic p;
        p = odd;
        for (int i = 0; i < nbits; i++) p = p ^ data[i];
        return parBit != p;
    endfunction

    task automatic pushExpect(input logic [7:0] data, input logic perr, input logic ferr);
        exp_t e;
        e.data = data;
        e.perr = perr;
        e.ferr = ferr;
        sbQ.push_back(e);
    endtask

    task automatic sendBit(input logic v);
        rx = v;
        repeat (BIT_CLK) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [7:0] data, input int nbits, input bit usePar,
                                 input logic parBit, input logic stop1, input logic stop2,
                                 input bit twoStop);
        sendBit(1'b0);
        for (int i = 0; i < nbits; i++) sendBit(data[i]);
        if (usePar) sendBit(parBit);
        sendBit(stop1);
        if (twoStop) sendBit(stop2);
        sendBit(1'b1);
    endtask

    task automatic checkOutput(input string tag);
        exp_t e;
        int   waitCnt;
        waitCnt = 0;
        while (rx_empty !== 1'b0 && waitCnt < 2000) begin
            @(negedge clk);
            waitCnt++;
        end
        checkValue({tag, " ready"}, {31'b0, rx_empty}, 32'd0);
        checkValue({tag, " sbq"}, {31'b0, (sbQ.size() > 0)}, 32'd1);
        if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkValue({tag, " word"}, {22'b0, r_data, r_perr, r_ferr}, {22'b0, e});
        end
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    // Directed sequence
    initial begin
        rx = 1'b1; reset = 1'b1; divisor = 11'd3;
        data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b0;
        rd_en = 1'b0; clr_overrun = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkValue("reset empty", {31'b0, rx_empty}, 32'd1);
        checkValue("reset full", {31'b0, rx_full}, 32'd0);
        checkValue("reset count", {27'b0, rx_count}, 32'd0);
        checkValue("reset head", {22'b0, r_data, r_perr, r_ferr}, 32'd0);
        checkValue("reset overrun", {31'b0, overrun}, 32'd0);
        checkValue("reset break", {31'b0, break_det}, 32'd0);

        // 8N1
        pushExpect(8'hA5, 1'b0, 1'b0);
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("8N1 A5");
        checkValue("8N1 empty after read", {31'b0, rx_empty}, 32'd1);

        // 7E1 and 7O1 parity
        data_bits = 2'b10; parity_mode = 2'b01;
        pushExpect(8'h41, expPerr(8'h41, 7, 1'b0, 1'b1), 1'b0);
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("7E1 p1");
        pushExpect(8'h41, expPerr(8'h41, 7, 1'b0, 1'b0), 1'b0);
        applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("7E1 p0");
        parity_mode = 2'b10;
        pushExpect(8'h41, expPerr(8'h41, 7, 1'b1, 1'b1), 1'b0);
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("7O1 p1");
        pushExpect(8'h41, expPerr(8'h41, 7, 1'b1, 1'b0), 1'b0);
        applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("7O1 p0");

        // 8N2 with a bad second stop bit
        data_bits = 2'b11; parity_mode = 2'b00; two_stop = 1'b1;
        brk0 = breakCnt;
        pushExpect(8'h3C, 1'b0, 1'b1);
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        checkOutput("8N2 ferr");
        checkValue("8N2 no break", breakCnt, brk0);

        // Break: line low for 20 bit times
        two_stop = 1'b0;
        brk0 = breakCnt;
        rx = 1'b0;
        repeat (20 * BIT_CLK) @(negedge clk);
        checkValue("break words while low", {27'b0, rx_count}, 32'd1);
        rx = 1'b1;
        repeat (3 * BIT_CLK) @(negedge clk);
        checkValue("break pulses", breakCnt, brk0 + 1);
        checkValue("break words after high", {27'b0, rx_count}, 32'd1);
        pushExpect(8'h00, 1'b0, 1'b1);
        checkOutput("break word");

        // Start glitch of 4 ticks
        rx = 1'b0;
        repeat (16) @(negedge clk);
        rx = 1'b1;
        repeat (4 * BIT_CLK) @(negedge clk);
        checkValue("glitch empty", {31'b0, rx_empty}, 32'd1);
        checkValue("glitch count", {27'b0, rx_count}, 32'd0);

        // Overflow: 17 frames, no reads
        for (int i = 0; i < 17; i++) begin
            d = 8'(i * 13 + 7);
            if (i < 16) pushExpect(d, 1'b0, 1'b0);
            applyStimulus(d, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        end
        checkValue("ovf full", {31'b0, rx_full}, 32'd1);
        checkValue("ovf count", {27'b0, rx_count}, 32'd16);
        checkValue("ovf overrun", {31'b0, overrun}, 32'd1);
        for (int i = 0; i < 16; i++) checkOutput("ovf read");
        checkValue("ovf drained", {31'b0, rx_empty}, 32'd1);
        checkValue("ovf sticky", {31'b0, overrun}, 32'd1);
        clr_overrun = 1'b1;
        @(negedge clk);
        clr_overrun = 1'b0;
        checkValue("ovf cleared", {31'b0, overrun}, 32'd0);

        // Reset during data bit 4
        sendBit(1'b0);
        for (int i = 0; i < 4; i++) sendBit(1'b1);
        rx = 1'b0;
        repeat (BIT_CLK / 2) @(negedge clk);
        reset = 1'b1;
        rx = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkValue("midreset empty", {31'b0, rx_empty}, 32'd1);
        checkValue("midreset count", {27'b0, rx_count}, 32'd0);
        checkValue("midreset head", {22'b0, r_data, r_perr, r_ferr}, 32'd0);
        repeat (12 * BIT_CLK) @(negedge clk);
        checkValue("midreset no word", {31'b0, rx_empty}, 32'd1);
        pushExpect(8'h5A, 1'b0, 1'b0);
        applyStimulus(8'h5A, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("post reset 5A");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
